ser2par_ctrl: RTL
=================

SER2PAR_CTRL -- requirements
Module: ser2par_ctrl

Interface
REQ-001 SHALL have parameter: bitlen, 8, number of serial bits per parallel word (range 2..16).
REQ-002 SHALL have port: Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: Rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: SerDataIn  input  1  serial data bit, sampled on Clk rising edge when SerDataEn=1.
REQ-005 SHALL have port: SerDataEn  input  1  serial bit qualifier; a continuous high run forms one frame.
REQ-006 SHALL have port: ParDataOut  output  bitlen  head word of output buffer.
REQ-007 SHALL have port: ParDataValid  output  1  output buffer not empty; ParDataOut is valid.
REQ-008 SHALL have port: ParDataReady  input  1  consumer accepts head word when ParDataValid=1.
REQ-009 SHALL have port: FrameErr  output  1  one-cycle pulse: frame ended mid-word.
REQ-010 SHALL have port: Overrun  output  1  one-cycle pulse: completed word dropped, buffer full.
REQ-011 SHALL have port: Busy  output  1  high while state is SHIFT.

Function
REQ-012 SHALL implement two states: IDLE, SHIFT.
REQ-013 SHALL, in IDLE with SerDataEn=1, store SerDataIn as bit 0, set bit counter to 1, enter SHIFT.
REQ-014 SHALL, in SHIFT with SerDataEn=1, store SerDataIn at bit position = counter (LSB first), increment counter.
REQ-015 SHALL, on the edge sampling bit bitlen-1, complete the word, reset counter to 0, remain in SHIFT (back-to-back words with no gap cycle).
REQ-016 SHALL, in SHIFT with SerDataEn=0 and counter=0, return to IDLE with no error.
REQ-017 SHALL, in SHIFT with SerDataEn=0 and counter!=0, discard partial word, pulse FrameErr for exactly one cycle, return to IDLE.
REQ-018 SHALL clear unsampled shift-register bits at each word start; no stale bits leak between words.
REQ-019 SHALL hold completed words in a 2-entry FIFO; write occurs on the same edge the last bit is sampled.
REQ-020 SHALL assert ParDataValid from the edge following the write, i.e. on the cycle after the last bit is presented (latency 1 cycle).
REQ-021 SHALL pop head word on each edge where ParDataValid=1 and ParDataReady=1; ParDataOut is don't-care when ParDataValid=0 but SHALL be stable while Valid=1 and Ready=0.
REQ-022 SHALL, when FIFO holds 2 words and a word completes with a simultaneous pop, accept the new word (no overrun).
REQ-023 SHALL, when FIFO holds 2 words and a word completes without pop, drop the new word, keep existing contents, pulse Overrun one cycle.
REQ-024 SHALL permit push and pop on the same edge at any occupancy; occupancy unchanged when both occur and FIFO is non-empty.
REQ-025 SHALL ignore ParDataReady when ParDataValid=0 (no underflow, pointers unchanged).
REQ-026 SHALL preserve word ordering: first completed word is first output.

Reset
REQ-027 SHALL, while Rst=1, force state IDLE, counter 0, shift register 0, FIFO empty.
REQ-028 SHALL drive reset outputs: ParDataOut=0, ParDataValid=0, FrameErr=0, Overrun=0, Busy=0.
REQ-029 SHALL, on Rst assertion mid-word, discard the partial word without FrameErr pulse, and discard FIFO contents.
REQ-030 SHALL, after Rst deassertion, start a new word only on the first edge sampling SerDataEn=1.

Verification
REQ-031 SHALL verify single word: bitlen=8, send 0x2B LSB-first (1,1,0,1,0,1,0,0) with SerDataEn=1 for 8 cycles, Ready=1 -> ParDataValid=1 for exactly one cycle, ParDataOut=0x2B, no error pulses.
REQ-032 SHALL verify short frame: 4 bits (1,0,1,1) then SerDataEn=0 -> FrameErr pulses one cycle, ParDataValid stays 0, Busy falls.
REQ-033 SHALL verify back-to-back: 16 cycles continuous SerDataEn with 0xA5 then 0x3C, Ready=1 -> outputs 0xA5 then 0x3C, 8 cycles apart, in order.
REQ-034 SHALL verify overrun: Ready=0, send 0x11, 0x22, 0x33 -> 0x33 dropped, Overrun pulses once; then Ready=1 -> 0x11, 0x22 popped, then Valid=0.
REQ-035 SHALL verify full with simultaneous pop: FIFO holds 0x11, 0x22; Ready=1 on the edge 0x33 completes -> outputs 0x11, 0x22, 0x33, no Overrun.
REQ-036 SHALL verify reset mid-word: Rst pulsed after 5 bits, then full 0x5A sent -> only 0x5A output, no FrameErr.

Source files
------------

// File: rtl/ser2par_ctrl.sv
// ser2par_ctrl: serial-to-parallel converter with a 2-word output FIFO.
// Collects LSB-first serial bits qualified by SerDataEn into bitlen-wide
// words. A continuous SerDataEn run is one frame and may carry several
// back-to-back words. Completed words are queued for a ready/valid consumer.
//
// Ports:
//   Clk          rising-edge clock
//   Rst          asynchronous active-high reset
//   SerDataIn    serial data bit, sampled when SerDataEn=1
//   SerDataEn    serial bit qualifier / frame envelope
//   ParDataOut   head word of the output FIFO
//   ParDataValid FIFO not empty
//   ParDataReady consumer pops the head word when ParDataValid=1
//   FrameErr     one-cycle pulse: frame ended with a partial word
//   Overrun      one-cycle pulse: completed word dropped because FIFO full
//   Busy         high while a frame is being shifted in
module ser2par_ctrl #(
  parameter int unsigned bitlen = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              SerDataIn,
  input  logic              SerDataEn,
  output logic [bitlen-1:0] ParDataOut,
  output logic              ParDataValid,
  input  logic              ParDataReady,
  output logic              FrameErr,
  output logic              Overrun,
  output logic              Busy
);

  localparam int unsigned CntW = $clog2(bitlen);
  localparam logic [CntW-1:0] LastBit = CntW'(bitlen - 1);

  typedef enum logic {
    Idle  = 1'b0,
    Shift = 1'b1
  } stateT;

  stateT             state;
  logic [CntW-1:0]   bitCnt;
  logic [bitlen-1:0] shiftReg;
  logic [bitlen-1:0] tailWord;
  logic [1:0]        fifoCnt;

  logic              wordDoneC;
  logic [bitlen-1:0] doneWordC;
  logic              popC;

  // Word completion, the completed word as written to the FIFO, and pop.
  always_comb begin
    wordDoneC = (state == Shift) && SerDataEn && (bitCnt == LastBit);
    doneWordC = {SerDataIn, shiftReg[bitlen-2:0]};
    popC      = ParDataValid && ParDataReady;
  end

  // Shift FSM and 2-entry FIFO; ParDataOut is the head register itself.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= Idle;
      bitCnt       <= '0;
      shiftReg     <= '0;
      tailWord     <= '0;
      fifoCnt      <= 2'd0;
      ParDataOut   <= '0;
      ParDataValid <= 1'b0;
      FrameErr     <= 1'b0;
      Overrun      <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;

      case (state)
        Idle: begin
          if (SerDataEn) begin
            // Word start: unsampled bits cleared so nothing stale leaks.
            shiftReg <= bitlen'(SerDataIn);
            bitCnt   <= CntW'(1);
            state    <= Shift;
            Busy     <= 1'b1;
          end
        end
        Shift: begin
          if (SerDataEn) begin
            if (bitCnt == '0) begin
              shiftReg <= bitlen'(SerDataIn);
            end else begin
              shiftReg[bitCnt] <= SerDataIn;
            end
            bitCnt <= wordDoneC ? '0 : bitCnt + CntW'(1);
          end else begin
            if (bitCnt != '0) begin
              FrameErr <= 1'b1;
            end
            bitCnt <= '0;
            state  <= Idle;
            Busy   <= 1'b0;
          end
        end
        default: begin
          state <= Idle;
          Busy  <= 1'b0;
        end
      endcase

      case (fifoCnt)
        2'd0: begin
          if (wordDoneC) begin
            ParDataOut   <= doneWordC;
            ParDataValid <= 1'b1;
            fifoCnt      <= 2'd1;
          end
        end
        2'd1: begin
          if (wordDoneC && popC) begin
            ParDataOut <= doneWordC;
          end else if (wordDoneC) begin
            tailWord <= doneWordC;
            fifoCnt  <= 2'd2;
          end else if (popC) begin
            ParDataValid <= 1'b0;
            fifoCnt      <= 2'd0;
          end
        end
        2'd2: begin
          if (popC) begin
            ParDataOut <= tailWord;
            if (wordDoneC) begin
              tailWord <= doneWordC;
            end else begin
              fifoCnt <= 2'd1;
            end
          end else if (wordDoneC) begin
            // Full and not draining: drop the new word, keep contents.
            Overrun <= 1'b1;
          end
        end
        default: begin
          fifoCnt      <= 2'd0;
          ParDataValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
